// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice. It holds the ALU control
// encodings, the default operand width and the result-slot state type.
package alu_arbiter_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
// Purely combinational ALU shared by both requesters.
// Ports:
//   ctrl   in  4     ALU control code (see alu_arbiter_pkg)
//   a, b   in  XLEN  operands
//   result out XLEN  ALU result; undefined codes produce 0
//   zero   out 1     result == 0
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto one shared combinational ALU and stores the
// outcome in a single registered result slot (1-cycle latency, 1 op/cycle).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req0_valid/ready/ctrl/a/b           requester 0 (pipeline execute)
//   req1_valid/ready/ctrl/a/b           requester 1 (address/branch unit)
//   resp_valid, resp_ready              result slot handshake
//   resp_id, resp_result, resp_zero     owner, ALU result and zero flag
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_ctrl,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_ctrl,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_zero
);

    slot_state_e     state, state_nxt;
    logic            ptr;
    logic            grant;
    logic            slot_free;
    logic            xfer;
    logic [3:0]      op_ctrl;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Contention is resolved by ptr; with no contention the lone requester
    // wins. With nothing valid grant follows ptr, which is harmless because
    // a ready without a valid never transfers.
    always_comb begin
        if (req0_valid && !req1_valid)      grant = 1'b0;
        else if (req1_valid && !req0_valid) grant = 1'b1;
        else                                grant = ptr;
    end

    assign slot_free  = (state == S_EMPTY) || resp_ready;
    // rst_n gates the readys so nothing looks accepted while reset is held.
    assign req0_ready = rst_n && slot_free && (grant == 1'b0);
    assign req1_ready = rst_n && slot_free && (grant == 1'b1);
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign op_ctrl = grant ? req1_ctrl : req0_ctrl;
    assign op_a    = grant ? req1_a    : req0_a;
    assign op_b    = grant ? req1_b    : req0_b;

    alu_arbiter_alu #(.XLEN(XLEN)) u_alu (
        .ctrl   (op_ctrl),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // Slot next state: a transfer always fills (also covers drain+accept);
    // a drain without a transfer empties.
    always_comb begin
        state_nxt = state;
        if (xfer)            state_nxt = S_FULL;
        else if (resp_ready) state_nxt = S_EMPTY;
    end

    // Slot outputs
    always_comb begin
        resp_valid = (state == S_FULL);
    end

    // Result payload and priority pointer only move on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_id     <= 1'b0;
            ptr         <= 1'b0;
        end else if (xfer) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_id     <= grant;
            ptr         <= ~grant;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed-vector bench for alu_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled 2 ns after the edge.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req0_ready;
    logic [3:0]      req0_ctrl;
    logic [XLEN-1:0] req0_a, req0_b;
    logic            req1_valid, req1_ready;
    logic [3:0]      req1_ctrl;
    logic [XLEN-1:0] req1_a, req1_b;
    logic            resp_valid, resp_ready, resp_id, resp_zero;
    logic [XLEN-1:0] resp_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_ctrl   (req0_ctrl),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_ctrl   (req1_ctrl),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
    );

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_ctrl = ALU_AND; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctrl = ALU_AND; req1_a = '0; req1_b = '0;
        resp_ready = 1'b0;
        step(); step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_result !== '0 || resp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b id=%b result=%0h zero=%b, required 0 0 0 0",
                     resp_valid, resp_id, resp_result, resp_zero);
        end
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 64'd5; req0_b = 64'd7;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_result !== 64'd12 || resp_zero !== 1'b0 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: valid=%b result=%0d zero=%b id=%b, required 1 12 0 0",
                     resp_valid, resp_result, resp_zero, resp_id);
        end
        step();
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_result !== 64'd12 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: valid=%b result=%0d id=%b, required 0 12 0",
                     resp_valid, resp_result, resp_id);
        end
    endtask

    // Reset with both requesters already valid, then release: req0 goes first.
    task automatic test_both_after_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_ctrl = ALU_SUB; req0_a = 64'd9; req0_b = 64'd9;
        req1_valid = 1'b1; req1_ctrl = ALU_ADD; req1_a = 64'd1; req1_b = 64'd2;
        resp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL first_grant: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 64'd0 || resp_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL both_c1: valid=%b id=%b result=%0d zero=%b, required 1 0 0 1",
                     resp_valid, resp_id, resp_result, resp_zero);
        end
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL both_c1_ready: ready0=%b ready1=%b, required 0 1", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_result !== 64'd3 || resp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL both_c2: valid=%b id=%b result=%0d zero=%b, required 1 1 3 0",
                     resp_valid, resp_id, resp_result, resp_zero);
        end
        step();
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_ctrl = ALU_AND; req0_a = 64'hF0; req0_b = 64'h3C;
        resp_ready = 1'b0;
        step();
        req1_ctrl = ALU_OR; req1_a = 64'h5; req1_b = 64'hA;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp_valid !== 1'b1 ||
                resp_result !== 64'h30 || resp_id !== 1'b0 || resp_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: r0=%b r1=%b valid=%b result=%0h id=%b zero=%b, required 0 0 1 30 0 0",
                         i, req0_ready, req1_ready, resp_valid, resp_result, resp_id, resp_zero);
            end
            step();
        end
        req0_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain_ready: ready0=%b ready1=%b, required 0 1", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_result !== 64'hF || resp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain_accept: valid=%b result=%0h id=%b, required 1 f 1",
                     resp_valid, resp_result, resp_id);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] exp_res;
        req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 64'd10; req0_b = 64'd1;
        req1_valid = 1'b1; req1_ctrl = ALU_SUB; req1_a = 64'd20; req1_b = 64'd5;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 5) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            exp_res = (i % 2 == 0) ? 64'd11 : 64'd15;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_id !== 1'((i % 2)) || resp_result !== exp_res) begin
                n_fail++;
                $display("FAIL b2b[%0d]: valid=%b id=%b result=%0d, required 1 %0d %0d",
                         i, resp_valid, resp_id, resp_result, i % 2, exp_res);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        req1_valid = 1'b1; req1_ctrl = ALU_ADD; req1_a = 64'd3; req1_b = 64'd4;
        resp_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_result !== 64'd7 || resp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load: valid=%b result=%0d id=%b, required 1 7 1",
                     resp_valid, resp_result, resp_id);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_result !== '0 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: valid=%b result=%0d id=%b, required 0 0 0",
                     resp_valid, resp_result, resp_id);
        end
        step();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        step(); step();
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_result !== '0) begin
            n_fail++;
            $display("FAIL mid_stale: valid=%b result=%0d, required 0 0", resp_valid, resp_result);
        end
    endtask

    task automatic test_drop_full();
        req0_valid = 1'b1; req0_ctrl = ALU_ADD; req0_a = 64'd2; req0_b = 64'd2;
        resp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_ctrl = ALU_OR; req1_a = 64'h100; req1_b = 64'h1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_ready: ready1=%b, required 0", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 64'd4) begin
            n_fail++;
            $display("FAIL drop_held: valid=%b id=%b result=%0d, required 1 0 4",
                     resp_valid, resp_id, resp_result);
        end
        step();
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_noresp: valid=%b id=%b, required 0 0", resp_valid, resp_id);
        end
        // ptr stays at 1 from the req0 transfer, so contention goes to req1.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_ctrl = ALU_AND; req1_a = 64'hFF; req1_b = 64'h0F;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_ptr: ready0=%b ready1=%b, required 0 1", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_result !== 64'h0F) begin
            n_fail++;
            $display("FAIL drop_after: valid=%b id=%b result=%0h, required 1 1 f",
                     resp_valid, resp_id, resp_result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_both_after_reset();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_drop_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 64, operand and result width.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 (pipeline execute) has an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_ctrl  input  4  requester 0 ALU control code.
REQ-007 req0_a, req0_b  input  XLEN each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_ctrl, req1_a, req1_b  same widths and directions  requester 1 (address/branch unit).
REQ-009 resp_valid  output  1  result slot holds a valid result.
REQ-010 resp_ready  input  1  consumer takes the result this cycle.
REQ-011 resp_id  output  1  index of the requester that owns the result.
REQ-012 resp_result  output  XLEN  ALU result.
REQ-013 resp_zero  output  1  ALU zero flag for resp_result.

Function
REQ-014 Shares one combinational ALU between two requesters; one registered result slot.
REQ-015 slot_free = !resp_valid | resp_ready.
REQ-016 Grant: only req0 valid -> 0; only req1 valid -> 1; both valid -> requester named by priority pointer ptr.
REQ-017 reqN_ready = slot_free & (grant == N); at most one ready high per cycle; ready never high when slot not free.
REQ-018 A transfer occurs on reqN_valid & reqN_ready; operands and ctrl are sampled that cycle only.
REQ-019 Latency is 1 cycle: the edge after a transfer, resp_valid=1, resp_result/resp_zero = ALU(ctrl, a, b), resp_id = N.
REQ-020 After a transfer from N, ptr = !N; ptr is unchanged on cycles with no transfer.
REQ-021 While resp_valid & !resp_ready, resp_result, resp_zero and resp_id are held stable and no request is accepted.
REQ-022 Simultaneous drain and accept (resp_ready and a transfer in the same cycle) loads the new result; sustained throughput is one operation per cycle.
REQ-023 Drain with no transfer clears resp_valid at the next edge; result/zero/id hold their last values.
REQ-024 Alternating service: with both valid continuously and resp_ready=1, grants alternate 0,1,0,1...
REQ-025 Undefined ctrl codes are passed to the ALU unchanged; the arbiter does not check them.
REQ-026 A requester's valid may drop without a transfer; no state is changed by it.

Reset
REQ-027 While rst_n=0: resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, ptr=0; both readys low.
REQ-028 Reset mid-operation discards any held result; no response is produced for it.
REQ-029 First grant after reset with both valid goes to requester 0.

Structure
REQ-030 Shared package holds the ALU control encodings (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110) and XLEN default.
REQ-031 One sub-module: the existing alu, instantiated once, fed by the grant mux.
REQ-032 Slot control is a 2-state machine (EMPTY, FULL) plus a 1-bit ptr register.

Verification
REQ-033 Only req0: ADD a=5, b=7, resp_ready=1 -> next cycle resp_valid=1, result=12, zero=0, id=0.
REQ-034 Both valid at reset exit: req0 SUB 9-9, req1 ADD 1+2 -> cycle1: id=0, result=0, zero=1; cycle2: id=1, result=3.
REQ-035 Backpressure: result held, resp_ready=0 for 3 cycles -> result/id stable, both readys 0; resp_ready=1 with req1 valid -> drain and accept in the same cycle.
REQ-036 Both valid 6 cycles, resp_ready=1 -> id sequence 0,1,0,1,0,1; one result per cycle.
REQ-037 rst_n low while resp_valid=1 -> resp_valid=0 immediately (asynchronous); after release, no stale result appears.
REQ-038 req1 valid 1 cycle while the slot is full, then dropped -> no transfer, ptr unchanged, no response with id=1.
